// File: rtl/rr_arb16.sv
// Sixteen-way round-robin arbiter with bounded grant hold and one-hot enable decode.
// A grant lasts until its requester drops or MAX_HOLD cycles elapse; one idle cycle always follows.
module rr_arb16 #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state;
  logic [3:0]  ptr;
  logic [7:0]  hcnt;
  logic [3:0]  winner;
  logic        release_now;

  // First set request strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] p);
    logic [3:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = p + 4'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner      = rr_pick(req, ptr);
  assign release_now = !req[gnt_idx] || (hcnt == HOLD_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= 4'd0;
      ptr       <= 4'd15;
      hcnt      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en && (req != 16'h0000)) begin
            gnt_idx   <= winner;
            ptr       <= winner;
            gnt_valid <= 1'b1;
            hcnt      <= 8'd1;
            state     <= GRANT;
          end else begin
            gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          // en is deliberately ignored here: an active grant is never revoked by it.
          if (release_now) begin
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  // Decode from registered index/valid only, so gnt never follows req combinationally.
  always_comb begin
    gnt = 16'h0000;
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: tb/tb_rr_arb16.sv
// Directed bench for rr_arb16: expectations queued at drive time, compared after each edge.
module tb_rr_arb16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt8, gnt4;
  logic [3:0]  idx8, idx4;
  logic        vld8, vld4;

  int vectors = 0;
  int fails   = 0;

  typedef struct {
    logic [15:0] g;
    logic [3:0]  i;
    logic        v;
    bit          sel4;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rr_arb16 #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(vld8)
  );

  rr_arb16 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4)
  );

  // Queue the expected post-edge outputs, advance one edge, then pop and compare.
  task automatic step(input logic [15:0] g, input logic [3:0] i, input bit sel4, input string tag);
    exp_t e;
    logic [15:0] og;
    logic [3:0]  oi;
    logic        ov;
    sb.push_back('{g: g, i: i, v: (g != 16'h0000), sel4: sel4, tag: tag});
    @(posedge clk);
    #1;
    e  = sb.pop_front();
    og = e.sel4 ? gnt4 : gnt8;
    oi = e.sel4 ? idx4 : idx8;
    ov = e.sel4 ? vld4 : vld8;
    vectors++;
    assert (og === e.g) else begin
      fails++;
      $error("FAIL %s gnt observed %h expected %h", e.tag, og, e.g);
    end
    vectors++;
    assert (oi === e.i) else begin
      fails++;
      $error("FAIL %s gnt_idx observed %0d expected %0d", e.tag, oi, e.i);
    end
    vectors++;
    assert (ov === e.v) else begin
      fails++;
      $error("FAIL %s gnt_valid observed %b expected %b", e.tag, ov, e.v);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    req = 16'h0000;
    #1;

    // Reset held for two edges
    step(16'h0000, 4'd0, 1'b0, "reset8_a");
    step(16'h0000, 4'd0, 1'b0, "reset8_b");
    step(16'h0000, 4'd0, 1'b1, "reset4");

    // First grant: ptr=15 scans from 0
    rst = 1'b0;
    en  = 1'b1;
    req = 16'h8001;
    step(16'h0001, 4'd0, 1'b0, "first_grant");

    // Full contention: 8 grant cycles + 1 idle per requester, in index order
    req = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < ((k == 0) ? 7 : 8); c++)
        step(16'h0001 << k, 4'(k), 1'b0, "rotate_hold");
      step(16'h0000, 4'(k), 1'b0, "rotate_idle");
    end
    step(16'h0001, 4'd0, 1'b0, "rotate_wrap");

    // Voluntary release of requester 5 with 9 waiting
    req = 16'h0000;
    step(16'h0000, 4'd0, 1'b0, "drop0");
    req = 16'h0220;
    for (int c = 0; c < 3; c++)
      step(16'h0020, 4'd5, 1'b0, "grant5");
    req = 16'h0200;
    step(16'h0000, 4'd5, 1'b0, "release5");
    step(16'h0200, 4'd9, 1'b0, "grant9");
    req = 16'h0000;
    step(16'h0000, 4'd9, 1'b0, "release9");

    // Single persistent requester, MAX_HOLD=4 instance
    rst = 1'b1;
    step(16'h0000, 4'd0, 1'b1, "rst4_again");
    rst = 1'b0;
    req = 16'h0008;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++)
        step(16'h0008, 4'd3, 1'b1, "persist_hold");
      step(16'h0000, 4'd3, 1'b1, "persist_idle");
    end

    // Enable gating on the MAX_HOLD=8 instance (it is holding requester 3 here)
    req = 16'h0000;
    en  = 1'b0;
    step(16'h0000, 4'd3, 1'b0, "gate_clear");
    req = 16'h0010;
    for (int c = 0; c < 5; c++)
      step(16'h0000, 4'd3, 1'b0, "gate_blocked");
    en = 1'b1;
    step(16'h0010, 4'd4, 1'b0, "gate_open");
    en = 1'b0;
    for (int c = 0; c < 4; c++)
      step(16'h0010, 4'd4, 1'b0, "en_low_keeps");
    req = 16'h0000;
    step(16'h0000, 4'd4, 1'b0, "release4");

    // Reset in the middle of a grant to requester 12
    en  = 1'b1;
    req = 16'h1000;
    for (int c = 0; c < 5; c++)
      step(16'h1000, 4'd12, 1'b0, "grant12");
    rst = 1'b1;
    req = 16'hFFFF;
    step(16'h0000, 4'd0, 1'b0, "rst_midgrant");
    rst = 1'b0;
    step(16'h0001, 4'd0, 1'b0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/rr_arb16.md
# rr_arb16

Sixteen-way round-robin arbiter that shares one downstream resource, such as a bus, register-file write port or memory bank, among 16 requesters. The block picks one requester, holds the grant until that requester releases it or a hold limit expires, then rotates priority. The granted index drives a 4-to-16 enable decode, so the grant output is always one-hot or all-zero. It sits between the requester array and the shared datapath's select/enable lines.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles a single grant may last; legal range 1–255.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbiter enable; when low, no new grant is issued.
- req  input  16  request lines, bit i = requester i, level-sensitive.
- gnt  output  16  registered one-hot grant; all-zero when idle.
- gnt_idx  output  4  binary index of current grant; holds last value when idle.
- gnt_valid  output  1  high while any grant is active; equals OR of gnt.

## Operation
- State: 2-state FSM, IDLE and GRANT. Also holds last-grant pointer `ptr` (4 bits) and hold counter `hcnt` (8 bits).
- Reset (rst=1 at clock edge):
  - Next state is IDLE.
  - gnt=16'h0000, gnt_valid=0, gnt_idx=4'd0, ptr=4'd15, hcnt=0.
  - Reset takes priority over every other input, including mid-grant. The grant drops on the reset edge.
- IDLE:
  - If en=1 and req≠0, select the first set bit of req scanning ptr+1, ptr+2, … with wrap mod 16.
  - Load gnt_idx and ptr with the winner, set gnt_valid=1, set gnt to the decoded one-hot, set hcnt=1, and go to GRANT.
  - Otherwise stay in IDLE with gnt=0.
- GRANT, evaluated every edge:
  - Release occurs when req[gnt_idx]=0, or when hcnt==MAX_HOLD.
  - On release: go to IDLE, and gnt=0 and gnt_valid=0 from the next cycle. gnt_idx and ptr are kept.
  - Otherwise: stay in GRANT and increment hcnt.
  - en=0 does not revoke an active grant. It only blocks new grants from IDLE.
- Fairness:
  - ptr always equals the last granted index.
  - The just-released requester has lowest priority at the next arbitration.
  - A force-released requester that is the only requester regains the grant after the idle cycle.
- gnt is derived only from registered gnt_idx and gnt_valid, never from req combinationally.

## Timing
- Grant latency: req sampled high at edge N while IDLE with en=1, giving gnt valid after edge N, i.e. throughout cycle N+1.
- Release latency: req[gnt_idx] sampled low at edge M, giving gnt=0 after edge M.
- Dead cycle: at least one idle cycle (gnt=0) between any two grants, including back-to-back grants to different requesters. Minimum grant-to-grant period is MAX_HOLD+1 cycles under continuous contention.
- Maximum grant length: exactly MAX_HOLD cycles with gnt high when req stays asserted.
- MAX_HOLD=1: every grant lasts 1 cycle, alternating grant/idle.
- Worst-case wait for a continuously requesting line: 15·(MAX_HOLD+1) cycles after its request is first sampled while another requester holds the grant.
- Simultaneous events:
  - Release and new requests on the same edge: release wins, and new arbitration happens on the following edge from IDLE.
  - Requests from other lines during GRANT are ignored until IDLE.
- Outputs are glitch-free registered values and change only on clk rising edges.

## Test plan
- Reset/first grant:
  - Assert rst 2 cycles, check gnt=0, gnt_valid=0, gnt_idx=0.
  - Release rst with req=16'h8001, en=1: after 1 edge, gnt=16'h0001 and gnt_idx=0, because ptr=15 scans from 0.
- Rotation under full contention:
  - req=16'hFFFF held, MAX_HOLD=8.
  - Grants go 0,1,2,…,15,0 in order. Each lasts 8 cycles followed by 1 idle cycle. Period is 144 cycles per full rotation.
- Voluntary release:
  - Requester 5 granted, then req[5] drops after 3 grant cycles while req[9]=1.
  - gnt=0 for 1 cycle, then gnt=16'h0200 and gnt_idx=9.
- Single persistent requester:
  - Only req[3]=1 with MAX_HOLD=4.
  - gnt toggles as 4 cycles of 16'h0008 and 1 cycle of 0, repeating. gnt_idx stays 3.
- Enable gating:
  - With en=0 and req=16'h0010, gnt stays 0 indefinitely.
  - Set en=1: gnt=16'h0010 next cycle.
  - Drop en mid-grant: grant persists until req[4] drops.
- Reset mid-grant:
  - Requester 12 granted with hcnt=5, assert rst for 1 edge.
  - gnt=0 and gnt_idx=0 next cycle.
  - After release with req=16'hFFFF, the first grant goes to index 0.
